// File: rtl/fetch_pc_gen.sv
// Raisin64 fetch-PC sequencer: issues imem requests, hands words to decode, drains on redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN: odd redirect targets go to TRAP_VECTOR and pulse misalign_flt.
module fetch_pc_gen #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned FETCH_BYTES  = 8,
  parameter logic [63:0] TRAP_VECTOR  = 64'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_jump,
  input  logic [63:0] jump_pc,
  input  logic        stall,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [63:0] imem_data,
  output logic [63:0] fetch_data,
  output logic [63:0] fetch_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic        flush,
  output logic        misalign_flt
);

  localparam logic [63:0] STEP       = 64'(FETCH_BYTES);
  localparam logic [63:0] ALIGN_MASK = ~(STEP - 64'd1);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pend_pc;
  logic [63:0] jump_target;
  logic        req_hold;
  logic        req_stuck;
  logic        jump_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign jump_bad = jump_pc[0];
`else
  assign jump_bad = 1'b0;
`endif

  assign jump_target = jump_bad ? TRAP_VECTOR : jump_pc;
  // An issued request that is not completing this cycle must be waited out.
  assign req_stuck   = imem_req & ~imem_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (do_jump && req_stuck) state_nxt = DRAIN;
      DRAIN:   if (imem_ack) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc & ALIGN_MASK;
    case (state)
      FETCH:   imem_req = req_hold | (~stall & (~fetch_valid | fetch_ready));
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // PC, pending redirect target and decode-side holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_VECTOR;
      pend_pc      <= '0;
      req_hold     <= 1'b0;
      fetch_valid  <= 1'b0;
      fetch_data   <= '0;
      fetch_pc     <= '0;
      flush        <= 1'b0;
      misalign_flt <= 1'b0;
    end else begin
      req_hold     <= req_stuck;
      flush        <= do_jump;
      misalign_flt <= do_jump & jump_bad;
      case (state)
        BOOT: begin
          if (do_jump) pc <= jump_target;
        end
        FETCH: begin
          if (do_jump) begin
            fetch_valid <= 1'b0;
            if (req_stuck) pend_pc <= jump_target;
            else           pc      <= jump_target;
          end else if (imem_req && imem_ack) begin
            fetch_data  <= imem_data;
            fetch_pc    <= pc;
            fetch_valid <= 1'b1;
            pc          <= (pc & ALIGN_MASK) + STEP;
          end else if (fetch_ready) begin
            fetch_valid <= 1'b0;
          end
        end
        DRAIN: begin
          fetch_valid <= 1'b0;
          if (do_jump) pend_pc <= jump_target;
          // Newest redirect wins even when it lands on the draining ack.
          if (imem_ack) pc <= do_jump ? jump_target : pend_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: scripted imem responder plus an expected-word scoreboard.
module tb_fetch_pc_gen;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst, do_jump, stall, imem_ack, fetch_ready;
  logic [63:0] jump_pc, imem_data;
  logic [63:0] imem_addr, fetch_data, fetch_pc;
  logic        imem_req, fetch_valid, flush, misalign_flt;

  int n_checks = 0;
  int n_pass   = 0;
  int budget, mem_lat, wait_cnt;
  logic        acc, o_req, o_valid, o_flush, o_flt;
  logic [63:0] o_pc, o_data, o_addr;
  sb_t         exp_q[$];
  sb_t         e;

  fetch_pc_gen dut (
    .clk(clk), .rst(rst), .do_jump(do_jump), .jump_pc(jump_pc), .stall(stall),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .flush(flush), .misalign_flt(misalign_flt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_of(input logic [63:0] a);
    return a ^ (a << 17) ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  function automatic void push_exp(input logic [63:0] p, input logic [63:0] a);
    sb_t t;
    t.pc   = p;
    t.data = word_of(a);
    exp_q.push_back(t);
  endfunction

  // One cycle: sample outputs at negedge, answer the request, return just after posedge.
  task automatic tick();
    @(negedge clk);
    acc = fetch_valid & fetch_ready;
    o_pc = fetch_pc; o_data = fetch_data; o_valid = fetch_valid;
    o_req = imem_req; o_addr = imem_addr; o_flush = flush; o_flt = misalign_flt;
    if (!rst && imem_req) begin
      if (wait_cnt >= mem_lat && budget > 0) begin
        imem_ack = 1'b1; imem_data = word_of(imem_addr); budget--; wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    @(posedge clk); #1;
    imem_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; stall = 1'b1; fetch_ready = 1'b0; do_jump = 1'b0; jump_pc = '0;
    imem_ack = 1'b0; imem_data = '0; budget = 0; mem_lat = 0; wait_cnt = 0;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    stall = 1'b0; budget = 1;
    repeat (4) tick();
    n_checks++; if (o_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b exp 1", o_valid); else n_pass++;
    rst = 1'b1;
    repeat (2) tick();
    n_checks++; if (o_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", o_req); else n_pass++;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", o_valid); else n_pass++;
    n_checks++; if ({o_flush, o_flt} !== 2'b00) $display("FAIL rst_pulses: got %b exp 00", {o_flush, o_flt}); else n_pass++;
    n_checks++; if ({o_pc, o_data} !== 128'd0) $display("FAIL rst_fetch_regs: got pc=%h data=%h exp 0", o_pc, o_data); else n_pass++;
    rst = 1'b0; fetch_ready = 1'b1; budget = 0;
    tick();
    n_checks++; if (o_req !== 1'b0) $display("FAIL boot_req: got %b exp 0", o_req); else n_pass++;
    tick();
    n_checks++; if ({o_req, o_addr} !== {1'b1, 64'h0}) $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=0", o_req, o_addr); else n_pass++;
  endtask

  task automatic test_sequential();
    apply_reset();
    stall = 1'b0; fetch_ready = 1'b1; budget = 3;
    push_exp(64'h0, 64'h0); push_exp(64'h8, 64'h8); push_exp(64'h10, 64'h10);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        n_checks++; if (o_req !== 1'b0) $display("FAIL seq_boot: got req=%b exp 0", o_req); else n_pass++;
      end else if (k <= 3) begin
        n_checks++;
        if ({o_req, o_addr} !== {1'b1, 64'(8 * (k - 1))})
          $display("FAIL seq_addr%0d: got req=%b addr=%h exp req=1 addr=%h", k, o_req, o_addr, 64'(8 * (k - 1)));
        else n_pass++;
      end
      if (acc) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL seq_word: got pc=%h, none expected", o_pc);
        else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_data !== e.data) $display("FAIL seq_word: got pc=%h data=%h exp pc=%h data=%h", o_pc, o_data, e.pc, e.data);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL seq_missing: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    stall = 1'b0; budget = 3;
    push_exp(64'h0, 64'h0); push_exp(64'h8, 64'h8); push_exp(64'h10, 64'h10);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 2 && k <= 4) begin
        n_checks++;
        if ({o_req, o_valid, o_pc} !== {1'b0, 1'b1, 64'h0})
          $display("FAIL bp_hold%0d: got req=%b valid=%b pc=%h exp req=0 valid=1 pc=0", k, o_req, o_valid, o_pc);
        else n_pass++;
      end
      if (k == 4) fetch_ready = 1'b1;
      if (k == 6) begin
        n_checks++; if (o_valid !== 1'b1) $display("FAIL bp_reload_valid: got %b exp 1", o_valid); else n_pass++;
      end
      if (acc) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_word: got pc=%h, none expected", o_pc);
        else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_data !== e.data) $display("FAIL bp_word: got pc=%h data=%h exp pc=%h data=%h", o_pc, o_data, e.pc, e.data);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_missing: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stall();
    apply_reset();
    stall = 1'b0; fetch_ready = 1'b1; mem_lat = 3; budget = 2;
    push_exp(64'h0, 64'h0); push_exp(64'h8, 64'h8);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if ({o_req, o_addr} !== {1'b1, 64'h0}) $display("FAIL stall_held%0d: got req=%b addr=%h exp req=1 addr=0", k, o_req, o_addr);
        else n_pass++;
      end
      if (k >= 5 && k <= 7) begin
        n_checks++; if (o_req !== 1'b0) $display("FAIL stall_noreq%0d: got req=%b exp 0", k, o_req); else n_pass++;
      end
      if (k == 1) stall = 1'b1;
      if (k == 7) stall = 1'b0;
      if (acc) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stall_word: got pc=%h, none expected", o_pc);
        else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_data !== e.data) $display("FAIL stall_word: got pc=%h data=%h exp pc=%h data=%h", o_pc, o_data, e.pc, e.data);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL stall_missing: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    stall = 1'b0; fetch_ready = 1'b1; budget = 4;
    push_exp(64'h0, 64'h0); push_exp(64'h8, 64'h8); push_exp(64'h10, 64'h10); push_exp(64'h18, 64'h18);
    push_exp(64'h1006, 64'h1000);
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 5 || k == 8) begin
        n_checks++; if ({o_req, o_addr} !== {1'b1, 64'h20}) $display("FAIL rp_old_addr%0d: got req=%b addr=%h exp req=1 addr=20", k, o_req, o_addr); else n_pass++;
      end
      if (k == 7) begin
        n_checks++;
        if ({o_flush, o_valid, o_req, o_addr} !== {1'b1, 1'b0, 1'b1, 64'h20})
          $display("FAIL rp_flush: got flush=%b valid=%b req=%b addr=%h exp flush=1 valid=0 req=1 addr=20", o_flush, o_valid, o_req, o_addr);
        else n_pass++;
      end
      if (k == 8) begin
        n_checks++; if (o_flush !== 1'b0) $display("FAIL rp_flush_width: got %b exp 0", o_flush); else n_pass++;
      end
      if (k == 9) begin
        n_checks++; if ({o_req, o_addr} !== {1'b1, 64'h1000}) $display("FAIL rp_new_addr: got req=%b addr=%h exp req=1 addr=1000", o_req, o_addr); else n_pass++;
      end
      if (k == 5) begin do_jump = 1'b1; jump_pc = 64'h1006; end
      if (k == 6) do_jump = 1'b0;
      if (k == 7) budget = 2;
      if (acc) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rp_word: got pc=%h, none expected", o_pc);
        else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_data !== e.data) $display("FAIL rp_word: got pc=%h data=%h exp pc=%h data=%h", o_pc, o_data, e.pc, e.data);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL rp_missing: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_jump_coincident();
    apply_reset();
    stall = 1'b0; fetch_ready = 1'b1; budget = 2;
    push_exp(64'h0, 64'h0); push_exp(64'h3000, 64'h3000); push_exp(64'h5008, 64'h5008);
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 3) begin
        n_checks++;
        if ({o_flush, o_valid, o_req, o_addr} !== {1'b1, 1'b0, 1'b1, 64'h3000})
          $display("FAIL jc_redirect: got flush=%b valid=%b req=%b addr=%h exp flush=1 valid=0 req=1 addr=3000", o_flush, o_valid, o_req, o_addr);
        else n_pass++;
      end
      if (k == 7 || k == 8) begin
        n_checks++; if (o_flush !== 1'b1) $display("FAIL jc_drain_flush%0d: got %b exp 1", k, o_flush); else n_pass++;
      end
      if (k == 9) begin
        n_checks++;
        if ({o_flush, o_req, o_addr} !== {1'b0, 1'b1, 64'h5008})
          $display("FAIL jc_newest_wins: got flush=%b req=%b addr=%h exp flush=0 req=1 addr=5008", o_flush, o_req, o_addr);
        else n_pass++;
      end
      if (k == 1) begin do_jump = 1'b1; jump_pc = 64'h3000; end
      if (k == 2) do_jump = 1'b0;
      if (k == 3) budget = 1;
      if (k == 5) begin do_jump = 1'b1; jump_pc = 64'h4000; end
      if (k == 6) jump_pc = 64'h5008;
      if (k == 7) begin do_jump = 1'b0; budget = 2; end
      if (acc) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL jc_word: got pc=%h, none expected", o_pc);
        else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_data !== e.data) $display("FAIL jc_word: got pc=%h data=%h exp pc=%h data=%h", o_pc, o_data, e.pc, e.data);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL jc_missing: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_misalign_wrap();
    logic [63:0] a0;
    a0 = MIS ? 64'h10 : 64'h2000;
    apply_reset();
    fetch_ready = 1'b1;
    push_exp(MIS ? 64'h10 : 64'h2001, a0); push_exp(a0 + 64'h8, a0 + 64'h8);
    push_exp(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8); push_exp(64'h0, 64'h0);
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 1) begin
        n_checks++; if (o_req !== 1'b0) $display("FAIL mw_stalled_req: got %b exp 0", o_req); else n_pass++;
      end
      if (k == 3) begin
        n_checks++;
        if ({o_flush, o_flt, o_req, o_addr} !== {1'b1, MIS, 1'b1, a0})
          $display("FAIL mw_target: got flush=%b flt=%b req=%b addr=%h exp flush=1 flt=%b req=1 addr=%h", o_flush, o_flt, o_req, o_addr, MIS, a0);
        else n_pass++;
      end
      if (k == 4) begin
        n_checks++;
        if ({o_flush, o_flt, o_addr} !== {1'b0, 1'b0, a0 + 64'h8})
          $display("FAIL mw_step: got flush=%b flt=%b addr=%h exp flush=0 flt=0 addr=%h", o_flush, o_flt, o_addr, a0 + 64'h8);
        else n_pass++;
      end
      if (k == 8) begin
        n_checks++; if ({o_flush, o_flt} !== 2'b10) $display("FAIL mw_drain_flush: got %b exp 10", {o_flush, o_flt}); else n_pass++;
      end
      if (k == 9) begin
        n_checks++; if (o_addr !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL mw_top_addr: got %h exp fffffffffffffff8", o_addr); else n_pass++;
      end
      if (k == 10) begin
        n_checks++; if (o_addr !== 64'h0) $display("FAIL mw_wrap_addr: got %h exp 0", o_addr); else n_pass++;
      end
      if (k == 1) begin do_jump = 1'b1; jump_pc = 64'h2001; end
      if (k == 2) begin do_jump = 1'b0; stall = 1'b0; budget = 2; end
      if (k == 6) begin do_jump = 1'b1; jump_pc = 64'hFFFF_FFFF_FFFF_FFFC; end
      if (k == 7) begin do_jump = 1'b0; budget = 3; end
      if (acc) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL mw_word: got pc=%h, none expected", o_pc);
        else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_data !== e.data) $display("FAIL mw_word: got pc=%h data=%h exp pc=%h data=%h", o_pc, o_data, e.pc, e.data);
          else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL mw_missing: got %0d outstanding exp 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_stall();
    test_redirect_pending();
    test_jump_coincident();
    test_misalign_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
